// File: rtl/sched_feeder.sv
// Feeds the PEG buffer scheduler: a show-ahead MK tile FIFO plus a KN column
// buffer that is replayed once per MK tile, with pops mirroring the scheduler's reads.
module sched_feeder #(
   parameter int NUM_PEGS      = 8,
   parameter int LOG2_PEGS     = 3,
   parameter int NUM_PES       = 8,
   parameter int LOG2_PES      = 3,
   parameter int DATA_TYPE     = 8,
   parameter int MK_DEPTH      = 4,
   parameter int LOG2_MK_DEPTH = 2,
   parameter int KN_DEPTH      = 16,
   parameter int LOG2_KN_DEPTH = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_start,
   input  logic [20:0]                                i_N_DIM,
   input  logic [15:0]                                i_M_TILES,
   input  logic                                       i_kn_wr_en,
   input  logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]      i_kn_wr_data,
   output logic                                       o_kn_ready,
   input  logic                                       i_mk_wr_en,
   input  logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]      i_mk_wr_data,
   input  logic [NUM_PEGS*NUM_PES*LOG2_PES-1:0]       i_mk_wr_dest,
   input  logic [NUM_PEGS*NUM_PES*LOG2_PEGS-1:0]      i_mk_wr_vn,
   input  logic [NUM_PEGS-1:0]                        i_mk_wr_add,
   input  logic [NUM_PEGS*LOG2_PEGS-1:0]              i_mk_wr_block_vn,
   input  logic [1:0]                                 i_mk_wr_accum,
   output logic                                       o_mk_full,
   input  logic                                       i_data_source,
   output logic                                       o_MK_data_valid,
   output logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]      o_MK_data_bus,
   output logic [NUM_PEGS*NUM_PES*LOG2_PES-1:0]       o_MK_dest_bus,
   output logic [NUM_PEGS*NUM_PES*LOG2_PEGS-1:0]      o_MK_vn_bus,
   output logic [NUM_PEGS-1:0]                        o_MK_add_bus,
   output logic [NUM_PEGS*LOG2_PEGS-1:0]              o_MK_block_vn,
   output logic [1:0]                                 o_MK_accum_ena,
   output logic                                       o_fifo_KN_data_empty,
   output logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]      o_KN_data_bus,
   output logic [15:0]                                o_tile_cnt,
   output logic                                       o_busy,
   output logic                                       o_done,
   output logic                                       o_err,
   output logic [1:0]                                 o_state_dbg
);
   localparam int DW     = NUM_PEGS*NUM_PES*DATA_TYPE;
   localparam int DEST_W = NUM_PEGS*NUM_PES*LOG2_PES;
   localparam int VN_W   = NUM_PEGS*NUM_PES*LOG2_PEGS;
   localparam int BVN_W  = NUM_PEGS*LOG2_PEGS;
   localparam int ENT_W  = DW + DEST_W + VN_W + NUM_PEGS + BVN_W + 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_KN = 2'd1,
      STREAM  = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [LOG2_KN_DEPTH-1:0]  n_last_q, n_last_d;
   logic [15:0]               m_tiles_q, m_tiles_d;
   logic [15:0]               tile_cnt_q, tile_cnt_d;
   logic [15:0]               mk_issued_q, mk_issued_d;
   logic [LOG2_KN_DEPTH-1:0]  kn_wr_ptr_q, kn_wr_ptr_d;
   logic [LOG2_KN_DEPTH-1:0]  kn_rd_ptr_q, kn_rd_ptr_d;
   logic                      ds_q;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic [DW-1:0]             kn_buf_q [KN_DEPTH];
   logic [ENT_W-1:0]          mk_mem_q [MK_DEPTH];
   logic [LOG2_MK_DEPTH-1:0]  mk_wr_ptr_q, mk_rd_ptr_q;
   logic [LOG2_MK_DEPTH:0]    mk_cnt_q;

   logic start_ok, kn_wr, kn_pop, kn_wrap, mk_full, mk_empty, mk_valid, mk_push, mk_pop;

   assign start_ok = (i_N_DIM != '0) && (i_N_DIM <= 21'(KN_DEPTH)) && (i_M_TILES != '0);
   assign kn_wr    = (state_q == LOAD_KN) && i_kn_wr_en;
   assign mk_full  = (mk_cnt_q == (LOG2_MK_DEPTH+1)'(MK_DEPTH));
   assign mk_empty = (mk_cnt_q == '0);
   assign mk_valid = (state_q == STREAM) && !mk_empty && (mk_issued_q < m_tiles_q);
   assign mk_push  = i_mk_wr_en && !mk_full;
   assign mk_pop   = i_data_source && mk_valid;
   // KN is read only after data_source has been low for two cycles, matching the scheduler.
   assign kn_pop   = !(i_data_source || ds_q || (state_q != STREAM));
   assign kn_wrap  = kn_pop && (kn_rd_ptr_q == n_last_q);

   always_comb begin
      state_d     = state_q;
      n_last_d    = n_last_q;
      m_tiles_d   = m_tiles_q;
      tile_cnt_d  = tile_cnt_q;
      mk_issued_d = mk_issued_q;
      kn_wr_ptr_d = kn_wr_ptr_q;
      kn_rd_ptr_d = kn_rd_ptr_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (start_ok) begin
                  n_last_d    = i_N_DIM[LOG2_KN_DEPTH-1:0] - LOG2_KN_DEPTH'(1);
                  m_tiles_d   = i_M_TILES;
                  tile_cnt_d  = '0;
                  mk_issued_d = '0;
                  kn_wr_ptr_d = '0;
                  kn_rd_ptr_d = '0;
                  state_d     = LOAD_KN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD_KN: begin
            if (i_kn_wr_en) begin
               kn_wr_ptr_d = kn_wr_ptr_q + LOG2_KN_DEPTH'(1);
               if (kn_wr_ptr_q == n_last_q) state_d = STREAM;
            end
         end
         STREAM: begin
            if (mk_pop) mk_issued_d = mk_issued_q + 16'd1;
            if (kn_wrap) begin
               kn_rd_ptr_d = '0;
               tile_cnt_d  = tile_cnt_q + 16'd1;
               if (tile_cnt_q + 16'd1 == m_tiles_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (kn_pop) begin
               kn_rd_ptr_d = kn_rd_ptr_q + LOG2_KN_DEPTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_last_q    <= '0;
         m_tiles_q   <= '0;
         tile_cnt_q  <= '0;
         mk_issued_q <= '0;
         kn_wr_ptr_q <= '0;
         kn_rd_ptr_q <= '0;
         ds_q        <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_last_q    <= n_last_d;
         m_tiles_q   <= m_tiles_d;
         tile_cnt_q  <= tile_cnt_d;
         mk_issued_q <= mk_issued_d;
         kn_wr_ptr_q <= kn_wr_ptr_d;
         kn_rd_ptr_q <= kn_rd_ptr_d;
         ds_q        <= i_data_source;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (kn_wr) kn_buf_q[kn_wr_ptr_q] <= i_kn_wr_data;
   end

   // MK FIFO: a write is judged against the occupancy before any same-cycle pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MK_DEPTH; i++) mk_mem_q[i] <= '0;
         mk_wr_ptr_q <= '0;
         mk_rd_ptr_q <= '0;
         mk_cnt_q    <= '0;
      end else begin
         if (mk_push) begin
            mk_mem_q[mk_wr_ptr_q] <= {i_mk_wr_data, i_mk_wr_dest, i_mk_wr_vn,
                                      i_mk_wr_add, i_mk_wr_block_vn, i_mk_wr_accum};
            mk_wr_ptr_q <= mk_wr_ptr_q + LOG2_MK_DEPTH'(1);
         end
         if (mk_pop) mk_rd_ptr_q <= mk_rd_ptr_q + LOG2_MK_DEPTH'(1);
         case ({mk_push, mk_pop})
            2'b10:   mk_cnt_q <= mk_cnt_q + (LOG2_MK_DEPTH+1)'(1);
            2'b01:   mk_cnt_q <= mk_cnt_q - (LOG2_MK_DEPTH+1)'(1);
            default: mk_cnt_q <= mk_cnt_q;
         endcase
      end
   end

   assign {o_MK_data_bus, o_MK_dest_bus, o_MK_vn_bus,
           o_MK_add_bus, o_MK_block_vn, o_MK_accum_ena} = mk_mem_q[mk_rd_ptr_q];

   assign o_MK_data_valid      = mk_valid;
   assign o_mk_full            = mk_full;
   assign o_kn_ready           = (state_q == LOAD_KN);
   assign o_fifo_KN_data_empty = (state_q != STREAM);
   assign o_KN_data_bus        = kn_buf_q[kn_rd_ptr_q];
   assign o_tile_cnt           = tile_cnt_q;
   assign o_busy               = (state_q != IDLE);
   assign o_done               = done_q;
   assign o_err                = err_q;
   assign o_state_dbg          = state_q;

endmodule

// File: tb/tb_sched_feeder.sv
// Randomized bench for sched_feeder: a scheduler model drives data_source and a
// monitor checks every MK/KN read against a queue of the expected read stream.
module tb_sched_feeder;
   localparam int NUM_PEGS = 8, LOG2_PEGS = 3, NUM_PES = 8, LOG2_PES = 3, DATA_TYPE = 8;
   localparam int MK_DEPTH = 4, LOG2_MK_DEPTH = 2, KN_DEPTH = 16, LOG2_KN_DEPTH = 4;
   localparam int DW     = NUM_PEGS*NUM_PES*DATA_TYPE;
   localparam int DEST_W = NUM_PEGS*NUM_PES*LOG2_PES;
   localparam int VN_W   = NUM_PEGS*NUM_PES*LOG2_PEGS;
   localparam int BVN_W  = NUM_PEGS*LOG2_PEGS;
   localparam int ENT_W  = DW + DEST_W + VN_W + NUM_PEGS + BVN_W + 2;

   logic clk, rst, i_start, i_kn_wr_en, i_mk_wr_en, i_data_source;
   logic [20:0] i_N_DIM;
   logic [15:0] i_M_TILES;
   logic [DW-1:0] i_kn_wr_data, i_mk_wr_data;
   logic [DEST_W-1:0] i_mk_wr_dest;
   logic [VN_W-1:0] i_mk_wr_vn;
   logic [NUM_PEGS-1:0] i_mk_wr_add;
   logic [BVN_W-1:0] i_mk_wr_block_vn;
   logic [1:0] i_mk_wr_accum;
   logic o_kn_ready, o_mk_full, o_MK_data_valid, o_fifo_KN_data_empty, o_busy, o_done, o_err;
   logic [DW-1:0] o_MK_data_bus, o_KN_data_bus;
   logic [DEST_W-1:0] o_MK_dest_bus;
   logic [VN_W-1:0] o_MK_vn_bus;
   logic [NUM_PEGS-1:0] o_MK_add_bus;
   logic [BVN_W-1:0] o_MK_block_vn;
   logic [1:0] o_MK_accum_ena, o_state_dbg;
   logic [15:0] o_tile_cnt;
   logic [ENT_W-1:0] mk_head;

   sched_feeder #(
      .NUM_PEGS(NUM_PEGS), .LOG2_PEGS(LOG2_PEGS), .NUM_PES(NUM_PES), .LOG2_PES(LOG2_PES),
      .DATA_TYPE(DATA_TYPE), .MK_DEPTH(MK_DEPTH), .LOG2_MK_DEPTH(LOG2_MK_DEPTH),
      .KN_DEPTH(KN_DEPTH), .LOG2_KN_DEPTH(LOG2_KN_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_N_DIM(i_N_DIM), .i_M_TILES(i_M_TILES),
      .i_kn_wr_en(i_kn_wr_en), .i_kn_wr_data(i_kn_wr_data), .o_kn_ready(o_kn_ready),
      .i_mk_wr_en(i_mk_wr_en), .i_mk_wr_data(i_mk_wr_data), .i_mk_wr_dest(i_mk_wr_dest),
      .i_mk_wr_vn(i_mk_wr_vn), .i_mk_wr_add(i_mk_wr_add), .i_mk_wr_block_vn(i_mk_wr_block_vn),
      .i_mk_wr_accum(i_mk_wr_accum), .o_mk_full(o_mk_full), .i_data_source(i_data_source),
      .o_MK_data_valid(o_MK_data_valid), .o_MK_data_bus(o_MK_data_bus),
      .o_MK_dest_bus(o_MK_dest_bus), .o_MK_vn_bus(o_MK_vn_bus), .o_MK_add_bus(o_MK_add_bus),
      .o_MK_block_vn(o_MK_block_vn), .o_MK_accum_ena(o_MK_accum_ena),
      .o_fifo_KN_data_empty(o_fifo_KN_data_empty), .o_KN_data_bus(o_KN_data_bus),
      .o_tile_cnt(o_tile_cnt), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_state_dbg(o_state_dbg)
   );

   assign mk_head = {o_MK_data_bus, o_MK_dest_bus, o_MK_vn_bus,
                     o_MK_add_bus, o_MK_block_vn, o_MK_accum_ena};

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference state ----------------
   int checks = 0, errors = 0;
   logic [DW:0]      exp_q[$];       // expected read stream: {is_mk, kn column}
   logic [ENT_W-1:0] mk_model_q[$];  // tiles the FIFO should hold, oldest first
   logic [DW-1:0]    kn_cols [KN_DEPTH];
   bit acc_now = 1'b0;
   bit mode_kn = 1'b0;
   bit ds_prev_m = 1'b0;
   bit done_prev = 1'b0;
   int kn_left = 0, job_n = 0, job_m = 0, reads_done = 0, done_seen = 0, err_seen = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_w(string name, logic [ENT_W-1:0] act, logic [ENT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got low64 %h expected low64 %h at %0t", name, act[63:0], exp[63:0], $time);
      end
   endfunction

   function automatic logic [ENT_W-1:0] rand_ent();
      logic [ENT_W-1:0] v = '0;
      repeat (30) v = {v[ENT_W-33:0], 32'($urandom())};
      return v;
   endfunction

   function automatic logic [DW-1:0] rand_dw();
      logic [DW-1:0] v = '0;
      repeat (16) v = {v[DW-33:0], 32'($urandom())};
      return v;
   endfunction

   // ---------------- scheduler model + monitor ----------------
   always @(negedge clk) begin
      logic mk_rd, kn_rd;
      logic [DW:0] e;
      i_data_source = !mode_kn;
      #1;
      if (rst) begin
         mode_kn = 1'b0;
         ds_prev_m = 1'b0;
         done_prev = 1'b0;
      end else begin
         chk("mk_full", 64'(o_mk_full), 64'((mk_model_q.size() - int'(acc_now)) == MK_DEPTH));
         if (o_done) begin
            done_seen++;
            chk("done_single_cycle", 64'(done_prev), 64'(0));
            chk("done_stream_drained", 64'(exp_q.size()), 64'(0));
            chk("done_tile_cnt", 64'(o_tile_cnt), 64'(job_m));
            chk("done_busy", 64'(o_busy), 64'(0));
         end
         if (o_err) err_seen++;
         done_prev = o_done;
         mk_rd = i_data_source && o_MK_data_valid;
         kn_rd = !i_data_source && !ds_prev_m && !o_fifo_KN_data_empty;
         if (mk_rd) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("mk_read_order", 64'(e[DW]), 64'(1));
            if (mk_model_q.size() == 0) chk("mk_read_fifo_nonempty", 64'(0), 64'(1));
            else chk_w("mk_read_head", mk_head, mk_model_q.pop_front());
            mode_kn = 1'b1;
            kn_left = job_n;
            reads_done++;
         end
         if (kn_rd) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {DW{1'b0}}};
            chk("kn_read_order", 64'(e[DW]), 64'(0));
            chk_w("kn_read_data", ENT_W'(o_KN_data_bus), ENT_W'(e[DW-1:0]));
            kn_left--;
            if (kn_left <= 0) mode_kn = 1'b0;
            reads_done++;
         end
         ds_prev_m = i_data_source;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      i_kn_wr_en = 1'b0;
      i_mk_wr_en = 1'b0;
      i_start    = 1'b0;
      acc_now    = 1'b0;
   endtask

   task automatic mk_write(logic [ENT_W-1:0] t);
      {i_mk_wr_data, i_mk_wr_dest, i_mk_wr_vn, i_mk_wr_add, i_mk_wr_block_vn, i_mk_wr_accum} = t;
      i_mk_wr_en = 1'b1;
      if (mk_model_q.size() < MK_DEPTH) begin
         mk_model_q.push_back(t);
         acc_now = 1'b1;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      mk_model_q.delete();
      exp_q.delete();
      reads_done = 0;
      step();
      rst = 1'b0;
   endtask

   task automatic reset_checks(string tag);
      chk({tag, "_mk_valid"}, 64'(o_MK_data_valid), 64'(0));
      chk({tag, "_kn_empty"}, 64'(o_fifo_KN_data_empty), 64'(1));
      chk({tag, "_done"}, 64'(o_done), 64'(0));
      chk({tag, "_err"}, 64'(o_err), 64'(0));
      chk({tag, "_busy"}, 64'(o_busy), 64'(0));
      chk({tag, "_kn_ready"}, 64'(o_kn_ready), 64'(0));
      chk({tag, "_tile_cnt"}, 64'(o_tile_cnt), 64'(0));
      chk({tag, "_mk_full"}, 64'(o_mk_full), 64'(0));
      chk({tag, "_state"}, 64'(o_state_dbg), 64'(0));
      chk_w({tag, "_mk_head"}, mk_head, '0);
   endtask

   task automatic start_job(int n, int m);
      step();
      i_start = 1'b1;
      i_N_DIM = 21'(n);
      i_M_TILES = 16'(m);
      job_n = n;
      job_m = m;
      reads_done = 0;
      for (int t = 0; t < m; t++) begin
         exp_q.push_back({1'b1, {DW{1'b0}}});
         for (int c = 0; c < n; c++) exp_q.push_back({1'b0, kn_cols[c]});
      end
   endtask

   task automatic load_kn(int n);
      for (int c = 0; c < n; c++) begin
         if ($urandom_range(3) == 0) step();
         step();
         chk("kn_ready_in_load", 64'(o_kn_ready), 64'(1));
         i_kn_wr_en = 1'b1;
         i_kn_wr_data = kn_cols[c];
      end
   endtask

   task automatic wait_done(int target, int budget, int wr_pct);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_seen >= target) begin
            ok = 1'b1;
            break;
         end
         if (int'($urandom_range(99)) < wr_pct) mk_write(rand_ent());
         if (o_busy && $urandom_range(99) < 3) begin
            i_start = 1'b1;
            i_N_DIM = 21'($urandom_range(16, 1));
            i_M_TILES = 16'($urandom_range(4, 1));
         end
      end
      if (!ok) begin
         chk("done_timeout", 64'(done_seen), 64'(target));
         apply_reset();
      end else begin
         chk("end_kn_empty", 64'(o_fifo_KN_data_empty), 64'(1));
         chk("end_busy", 64'(o_busy), 64'(0));
         chk("end_tile_cnt_hold", 64'(o_tile_cnt), 64'(job_m));
         chk("end_done_low", 64'(o_done), 64'(0));
      end
   endtask

   task automatic run_job(int n, int m, int wr_pct, bit preset);
      int target;
      if (!preset) for (int c = 0; c < n; c++) kn_cols[c] = rand_dw();
      target = done_seen + 1;
      start_job(n, m);
      load_kn(n);
      wait_done(target, m * (n + 4) + 400, wr_pct);
   endtask

   task automatic wait_reads(int count, int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (reads_done >= count) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("reads_timeout", 64'(reads_done), 64'(count));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [ENT_W-1:0] t0;
      int err_base, target;
      rst = 1'b1; i_start = 1'b0; i_N_DIM = '0; i_M_TILES = '0;
      i_kn_wr_en = 1'b0; i_kn_wr_data = '0; i_mk_wr_en = 1'b0; i_mk_wr_data = '0;
      i_mk_wr_dest = '0; i_mk_wr_vn = '0; i_mk_wr_add = '0; i_mk_wr_block_vn = '0;
      i_mk_wr_accum = '0;
      step(); step();
      apply_reset();
      reset_checks("reset");

      // Five writes into a four-deep FIFO: the fifth is dropped.
      t0 = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 4) chk("full_after_4_writes", 64'(o_mk_full), 64'(1));
         if (i == 0) begin
            t0 = rand_ent();
            mk_write(t0);
         end else mk_write(rand_ent());
      end
      step();
      chk("full_after_5_writes", 64'(o_mk_full), 64'(1));
      chk_w("full_head_is_first", mk_head, t0);
      chk("idle_mk_valid", 64'(o_MK_data_valid), 64'(0));
      run_job(2, 4, 0, 1'b0);

      // N_DIM=3, M_TILES=2 with columns A0..A2.
      for (int i = 0; i < 2; i++) begin step(); mk_write(rand_ent()); end
      for (int c = 0; c < 3; c++) kn_cols[c] = DW'(160 + c);
      run_job(3, 2, 0, 1'b1);

      // N_DIM=1: every KN read wraps.
      for (int i = 0; i < 3; i++) begin step(); mk_write(rand_ent()); end
      run_job(1, 3, 0, 1'b0);

      // Rejected starts.
      err_base = err_seen;
      for (int k = 0; k < 3; k++) begin
         step();
         i_start = 1'b1;
         i_N_DIM = (k == 0) ? 21'd0 : (k == 1) ? 21'd17 : 21'd3;
         i_M_TILES = (k == 2) ? 16'd0 : 16'd2;
         step();
         chk("err_pulse", 64'(o_err), 64'(1));
         chk("err_busy", 64'(o_busy), 64'(0));
         step();
         chk("err_pulse_end", 64'(o_err), 64'(0));
      end
      chk("err_count", 64'(err_seen - err_base), 64'(3));

      // MK FIFO runs dry at a tile boundary.
      step(); mk_write(rand_ent());
      for (int c = 0; c < 2; c++) kn_cols[c] = rand_dw();
      target = done_seen + 1;
      start_job(2, 2);
      load_kn(2);
      wait_reads(3, 200);
      repeat (20) step();
      chk("starved_mk_valid", 64'(o_MK_data_valid), 64'(0));
      chk("starved_kn_empty", 64'(o_fifo_KN_data_empty), 64'(0));
      chk("starved_busy", 64'(o_busy), 64'(1));
      chk("starved_tile_cnt", 64'(o_tile_cnt), 64'(1));
      chk("starved_reads", 64'(reads_done), 64'(3));
      step(); mk_write(rand_ent());
      wait_done(target, 300, 0);

      // Reset in the middle of STREAM (tile_cnt=1, kn_rd_ptr=2).
      for (int i = 0; i < 3; i++) begin step(); mk_write(rand_ent()); end
      for (int c = 0; c < 3; c++) kn_cols[c] = rand_dw();
      start_job(3, 3);
      load_kn(3);
      wait_reads(7, 200);
      chk("midrst_tile_cnt", 64'(o_tile_cnt), 64'(1));
      apply_reset();
      reset_checks("midrst");

      // Random jobs with background MK writes and ignored starts.
      for (int j = 0; j < 8; j++) begin
         repeat ($urandom_range(3)) begin step(); mk_write(rand_ent()); end
         run_job(int'($urandom_range(16, 1)), int'($urandom_range(4, 1)), 30, 1'b0);
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
